// File: rtl/seq_mult16.sv
// seq_mult16: 16x16 unsigned shift-and-add multiplier.
// One partial product is accumulated per clock through a single 16-bit ripple
// adder. Operands arrive and the product leaves over valid/ready handshakes.

// ripple_carry_adder: plain 16-bit ripple-carry adder, purely combinational.
module ripple_carry_adder (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Full-adder chain, LSB first, with the carry rippling up bit by bit
  always_comb begin
    logic [16:0] c;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 16; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
    cout = c[16];
  end

endmodule

module seq_mult16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] mcand;
  logic [15:0] acc_hi;
  logic [15:0] acc_lo;
  logic [4:0]  count;
  logic [15:0] addend;
  logic [15:0] sum;
  logic        cout;

  // The multiplier bit now sitting in acc_lo[0] selects whether mcand is added
  assign addend = acc_lo[0] ? mcand : 16'h0000;

  ripple_carry_adder u_adder (
    .x    (acc_hi),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // State register; reset always returns to IDLE and abandons any operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-only output decode
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == 5'd15) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, then shift {cout,sum,acc_lo} right once per iteration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a;
            acc_lo <= b;
            acc_hi <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= {cout, sum, acc_lo[15:1]};
          count            <= count + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign product = {acc_hi, acc_lo};

endmodule
